// File: rtl/swacc_icm_map_cmd_gen.sv
// ICM-map command generator: packs cfg/disable/map requests into map_req beats.
// Optional build macro SWACC_MAP_ADDR_CHECK_EN: clear misaligned icm_addr bits and flag map_err.
module swacc_icm_map_cmd_gen #(
    parameter int HEAD_W = 128,
    parameter int DATA_W = 256,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [55:0]       cfg_qpc_base,
    input  logic [7:0]        cfg_qpc_num_log,
    input  logic [55:0]       cfg_cqc_base,
    input  logic [7:0]        cfg_cqc_num_log,
    input  logic [55:0]       cfg_eqc_base,
    input  logic [7:0]        cfg_eqc_num_log,
    input  logic              dis_valid,
    output logic              dis_ready,
    input  logic              dis_sel,
    input  logic              map_valid,
    output logic              map_ready,
    input  logic [CNT_W-1:0]  map_chunk_num,
    input  logic              ent_valid,
    output logic              ent_ready,
    input  logic [63:0]       ent_icm_addr,
    input  logic [51:0]       ent_phy_addr,
    output logic              map_req_valid,
    output logic [HEAD_W-1:0] map_req_head,
    output logic [DATA_W-1:0] map_req_data,
    output logic              map_req_last,
    input  logic              map_req_ready,
    output logic              map_err
);

    localparam logic [3:0] T_WR_ICMMAP_CXT = 4'h5;
    localparam logic [3:0] T_MAP_ICM_CXT   = 4'h6;
    localparam logic [3:0] O_WR_ICMMAP_EN  = 4'h1;
    localparam logic [3:0] O_WR_ICMMAP_DIS = 4'h2;
    localparam logic [3:0] O_MAP_ICM_EN    = 4'h3;
    localparam logic [3:0] O_MAP_ICM_DIS   = 4'h4;

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_DIS, S_M_FIRST, S_M_HI, S_M_LO, S_EMIT
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [HEAD_W-1:0]   head_q, head_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic                idle;
    logic                beat_acc;
    logic                ent_acc;
    logic [63:0]         icm_eff;
    logic [127:0]        slot;

    // Request arbitration and entry acceptance (dis > cfg > map).
    always_comb begin
        idle      = (state_q == S_IDLE) && !rst;
        dis_ready = idle && dis_valid;
        cfg_ready = idle && cfg_valid && !dis_valid;
        map_ready = idle && map_valid && !dis_valid && !cfg_valid;
        ent_ready = !rst && !valid_q && (rem_q != '0) &&
                    ((state_q == S_M_FIRST) || (state_q == S_M_HI) ||
                     (state_q == S_M_LO));
        beat_acc  = valid_q && map_req_ready;
        ent_acc   = ent_valid && ent_ready;
`ifdef SWACC_MAP_ADDR_CHECK_EN
        icm_eff   = {ent_icm_addr[63:12], 12'h000};
`else
        icm_eff   = ent_icm_addr;
`endif
        slot      = {icm_eff, ent_phy_addr, 12'h000};
    end

    // Next-state, beat assembly and error pulse.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        head_d  = head_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (dis_ready) begin
                    head_d = '0;
                    if (dis_sel) begin
                        head_d[127:124] = T_MAP_ICM_CXT;
                        head_d[123:120] = O_MAP_ICM_DIS;
                    end else begin
                        head_d[127:124] = T_WR_ICMMAP_CXT;
                        head_d[123:120] = O_WR_ICMMAP_DIS;
                    end
                    data_d  = '0;
                    last_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_DIS;
                end else if (cfg_ready) begin
                    head_d          = '0;
                    head_d[127:124] = T_WR_ICMMAP_CXT;
                    head_d[123:120] = O_WR_ICMMAP_EN;
                    data_d          = '0;
                    data_d[63:0]    = {cfg_eqc_base, cfg_eqc_num_log};
                    data_d[127:64]  = {cfg_cqc_base, cfg_cqc_num_log};
                    data_d[191:128] = {cfg_qpc_base, cfg_qpc_num_log};
                    last_d          = 1'b1;
                    valid_d         = 1'b1;
                    state_d         = S_CFG;
                end else if (map_ready) begin
                    data_d = '0;
                    rem_d  = map_chunk_num;
                    if (map_chunk_num == '0) begin
                        head_d = '0;
                        err_d  = 1'b1;
                    end else begin
                        head_d          = '0;
                        head_d[127:124] = T_MAP_ICM_CXT;
                        head_d[123:120] = O_MAP_ICM_EN;
                        head_d[95:64]   = map_chunk_num;
                        state_d         = S_M_FIRST;
                    end
                end
            end
            S_CFG, S_DIS: begin
                if (beat_acc) begin
                    head_d  = '0;
                    data_d  = '0;
                    last_d  = 1'b0;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_M_FIRST: begin
                if (ent_acc) begin
                    data_d          = '0;
                    data_d[127:0]   = slot;
                    rem_d           = rem_q - CNT_W'(1);
                    last_d          = (rem_q == CNT_W'(1));
                    valid_d         = 1'b1;
                    state_d         = S_EMIT;
                end
            end
            S_M_HI: begin
                if (ent_acc) begin
                    data_d[255:128] = slot;
                    rem_d           = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        last_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = S_EMIT;
                    end else begin
                        state_d = S_M_LO;
                    end
                end
            end
            S_M_LO: begin
                if (ent_acc) begin
                    data_d[127:0] = slot;
                    rem_d         = rem_q - CNT_W'(1);
                    last_d        = (rem_q == CNT_W'(1));
                    valid_d       = 1'b1;
                    state_d       = S_EMIT;
                end
            end
            S_EMIT: begin
                if (beat_acc) begin
                    data_d  = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        head_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_M_HI;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef SWACC_MAP_ADDR_CHECK_EN
        if (ent_acc && (ent_icm_addr[11:0] != 12'h000)) begin
            err_d = 1'b1;
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            head_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            head_q  <= head_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign map_req_valid = valid_q;
    assign map_req_head  = head_q;
    assign map_req_data  = data_q;
    assign map_req_last  = last_q;
    assign map_err       = err_q;

endmodule
